// File: rtl/alu_result_fifo_if.sv
// -----------------------------------------------------------------------------
// alu_result_fifo_if
// Handshake bundle between the float_alu result channel, the result FIFO and
// the downstream consumer.
//   in_valid/in_result/in_flags/in_ready : ALU -> FIFO write side
//   out_valid/out_result/out_flags/out_ready : FIFO -> consumer read side
// Modports:
//   master : the environment around the FIFO (ALU producer + consumer)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface alu_result_fifo_if;
    logic        in_valid;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic        in_ready;

    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        out_ready;

    modport master (
        output in_valid, in_result, in_flags, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_result, in_flags, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// First-word-fall-through buffer for {flags, result} words produced by the
// float_alu. Backpressures the ALU through in_ready and presents the oldest
// word to a consumer over a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of contents and high-water mark
//   bus         : alu_result_fifo_if.slave (write and read handshakes)
//   count       : entries currently stored, 0..DEPTH
//   high_water  : largest count seen since reset/flush
//   full, empty : count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_result_fifo_if.slave bus,
    output logic [PTR_W:0]   count,
    output logic [PTR_W:0]   high_water,
    output logic             full,
    output logic             empty
);
    localparam int             CNT_W     = PTR_W + 1;
    localparam logic [PTR_W:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Entry layout: {flags[4:0], result[31:0]}; contents are never reset.
    logic [36:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   high_water_q, high_water_d;

    logic push;
    logic pop;
    logic full_int;
    logic empty_int;

    assign full_int  = (count_q == DEPTH_CNT);
    assign empty_int = (count_q == '0);

    // in_ready depends only on occupancy, never on in_valid.
    assign bus.in_ready  = !full_int;
    assign bus.out_valid = !empty_int;

    assign push = bus.in_valid  & !full_int;
    assign pop  = bus.out_ready & !empty_int;

    // Head word is read combinationally so it falls through without a bubble.
    assign bus.out_result = mem[rd_ptr_q][31:0];
    assign bus.out_flags  = mem[rd_ptr_q][36:32];

    assign count      = count_q;
    assign high_water = high_water_q;
    assign full       = full_int;
    assign empty      = empty_int;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        high_water_d = high_water_q;
        if (flush) begin
            // Flush wins over any transfer attempted in the same cycle.
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            high_water_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // count never exceeds DEPTH, so the mark saturates there naturally.
            if (count_d > high_water_q) high_water_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
        end
    end

    // Storage write port; a push coinciding with flush is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= {bus.in_flags, bus.in_result};
        end
    end
endmodule
